girl_motion_ctrl: RTL and testbench
===================================

Name: girl_motion_ctrl

Overview:
- Per-frame motion and sprite-address generator for the girl character. Sits directly upstream of the colour mapper.
- Converts keyboard keycodes into position, jump/gravity state and animation status once per frame.
- Per pixel, produces is_girl, girl_address and girl_status from DrawX/DrawY. The colour mapper consumes these to select and key out the girl sprite ROMs.

Parameters:
SPRITE_W, 32, sprite width in pixels (power of two)
SPRITE_H, 32, sprite height in pixels; SPRITE_W*SPRITE_H = 1024 fills girl_address
X_START, 40, reset X (top-left)
Y_START, 416, reset Y (top-left)
X_MAX, 639, rightmost screen column
Y_FLOOR, 416, top-left Y when standing on floor
X_STEP, 2, horizontal pixels per frame
JUMP_V, 12, initial upward speed (px/frame)
GRAVITY, 1, speed increment per frame
V_MAX, 12, maximum downward speed
KEY_LEFT / KEY_RIGHT / KEY_JUMP, 8'h04 / 8'h07 / 8'h1A, USB HID codes (A/D/W)

Ports:
Clk  in  1  system clock (50 MHz)
Reset_n  in  1  synchronous active-low reset
frame_clk  in  1  VGA vsync-derived frame tick, slow level signal
keycode0  in  8  first pressed key, 0 = none
keycode1  in  8  second pressed key, 0 = none
DrawX  in  10  current pixel X
DrawY  in  10  current pixel Y
is_girl  out  1  current pixel is inside sprite box
girl_address  out  10  sprite ROM address
girl_status  out  4  0000 idle, 0001 moving right, 0010 moving left
girl_x  out  10  registered top-left X
girl_y  out  10  registered top-left Y
in_air  out  1  1 while jumping or falling

Behaviour:
- Single clock domain (Clk); one clock; reset is synchronous and active-low (Reset_n, sampled on rising Clk).
- Reset: girl_x=X_START, girl_y=Y_START, vy=0, state=GROUND, girl_status=0000, in_air=0, frame_clk delay reg=0.
- Frame tick: frame_clk registered; tick = frame_clk & ~frame_clk_d, a one-Clk pulse on the rising edge. All motion state updates only on tick.
- Key decode: left/right/jump = match of KEY_* against keycode0 OR keycode1.
- Horizontal, on tick:
  - right only: girl_x = min(girl_x+X_STEP, X_MAX-SPRITE_W+1); girl_status=0001.
  - left only: girl_x = max(girl_x-X_STEP, 0), computed without unsigned wrap; girl_status=0010.
  - both or neither: girl_x unchanged; girl_status=0000.
  - Status reflects key intent even when clamped at a wall.
- Vertical FSM (vy signed 6 bit, negative = up):
  - GROUND: on tick with jump → AIR, vy=-JUMP_V, girl_y unchanged this tick. No jump → hold.
  - AIR: on tick compute ny = girl_y + vy, signed 11-bit.
    - ny >= Y_FLOOR → girl_y=Y_FLOOR, vy=0, GROUND.
    - ny < 0 → girl_y=0, vy=0, stay AIR (ceiling bump).
    - else girl_y=ny, vy = min(vy+GRAVITY, V_MAX).
  - Jump held while AIR is ignored; re-jump requires landing first. Holding jump on the landing tick does not jump; the next tick does.
- in_air = (state==AIR), registered.
- Pixel outputs, combinational from DrawX/DrawY and registered position, zero latency to match the colour mapper:
  - is_girl = DrawX>=girl_x && DrawX<girl_x+SPRITE_W && DrawY>=girl_y && DrawY<girl_y+SPRITE_H. Comparisons use 11-bit widths; no wrap.
  - girl_address = (DrawY-girl_y)*SPRITE_W + (DrawX-girl_x), truncated to 10 bits, when is_girl. Otherwise 0.
- Reset mid-jump: next Clk returns to reset values; a tick in the same cycle as reset is ignored.
- Keycode changes between ticks have no effect until the next tick.

Test Plan:
- Reset_n=0 for 2 clocks → girl_x=40, girl_y=416, girl_status=0000, in_air=0. DrawX=40,DrawY=416 → is_girl=1, girl_address=0. DrawX=71,DrawY=447 → address 1023. DrawX=72 → is_girl=0.
- keycode0=8'h07 for 3 ticks → girl_x 46, girl_status=0001. Start girl_x=606, 1 tick → girl_x=608 (clamp). Next tick stays 608, status still 0001.
- keycode0=8'h04 from girl_x=1 → girl_x=0 (no wrap to 1023), status 0010. keycode0=04, keycode1=07 → x unchanged, status 0000.
- keycode0=8'h1A one tick from ground → in_air=1, y=416. Following ticks y=404, 393, 383 …. After apex, lands at exactly 416 with in_air=0 at the landing tick (25 ticks after jump).
- Jump key held through landing → one grounded tick, then new jump starts. Jump pressed while in_air → vy trajectory unchanged.
- Assert Reset_n=0 mid-jump coincident with frame tick → next cycle y=416, in_air=0, vy=0. frame_clk held high for many Clk → only one update per edge.

Source files
------------

// File: rtl/girl_motion_ctrl.sv
// girl_motion_ctrl: per-frame girl sprite motion (walk, jump, gravity) and per-pixel sprite addressing
module girl_motion_ctrl #(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int X_START = 40,
  parameter int Y_START = 416,
  parameter int X_MAX = 639,
  parameter int Y_FLOOR = 416,
  parameter int X_STEP = 2,
  parameter int JUMP_V = 12,
  parameter int GRAVITY = 1,
  parameter int V_MAX = 12,
  parameter logic [7:0] KEY_LEFT = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07,
  parameter logic [7:0] KEY_JUMP = 8'h1A
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_girl,
  output logic [9:0] girl_address,
  output logic [3:0] girl_status,
  output logic [9:0] girl_x,
  output logic [9:0] girl_y,
  output logic       in_air
);
  localparam logic [0:0] GROUND = 1'b0;
  localparam logic [0:0] AIR = 1'b1;
  localparam logic [9:0] X_LIM = 10'(X_MAX - SPRITE_W + 1);
  logic frame_q, tick;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic signed [5:0] vy_q, vy_d, vy_inc;
  logic [0:0] st_q, st_d;
  logic [3:0] status_q, status_d;
  logic left, right, jump, go_r, go_l;
  logic [10:0] x_r;
  logic [9:0] x_rc, x_lc;
  logic signed [10:0] ny;
  logic [10:0] px, py, gx, gy;
  assign tick = frame_clk & ~frame_q;
  assign left = keycode0 == KEY_LEFT || keycode1 == KEY_LEFT;
  assign right = keycode0 == KEY_RIGHT || keycode1 == KEY_RIGHT;
  assign jump = keycode0 == KEY_JUMP || keycode1 == KEY_JUMP;
  assign go_r = right & ~left;
  assign go_l = left & ~right;
  assign x_r = {1'b0, x_q} + 11'(X_STEP);
  assign x_rc = x_r > {1'b0, X_LIM} ? X_LIM : x_r[9:0];
  assign x_lc = x_q < 10'(X_STEP) ? '0 : x_q - 10'(X_STEP);
  assign ny = $signed({1'b0, y_q}) + $signed({{5{vy_q[5]}}, vy_q});
  assign vy_inc = vy_q + 6'(GRAVITY);
  // Next-state motion: horizontal walk with wall clamps, vertical jump/gravity FSM, all gated by the frame tick
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    vy_d = vy_q;
    st_d = st_q;
    status_d = status_q;
    if (tick) begin
      status_d = go_r ? 4'b0001 : go_l ? 4'b0010 : 4'b0000;
      x_d = go_r ? x_rc : go_l ? x_lc : x_q;
      if (st_q == GROUND) begin
        if (jump) begin
          st_d = AIR;
          vy_d = 6'(-JUMP_V);
        end
      end else if (ny >= $signed(11'(Y_FLOOR))) begin
        y_d = 10'(Y_FLOOR);
        vy_d = '0;
        st_d = GROUND;
      end else if (ny[10]) begin
        y_d = '0;
        vy_d = '0;
      end else begin
        y_d = ny[9:0];
        vy_d = vy_inc > $signed(6'(V_MAX)) ? 6'(V_MAX) : vy_inc;
      end
    end
  end
  // State registers with synchronous active-low reset taking priority over any tick
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      frame_q <= 1'b0;
      x_q <= 10'(X_START);
      y_q <= 10'(Y_START);
      vy_q <= '0;
      st_q <= GROUND;
      status_q <= 4'b0000;
    end else begin
      frame_q <= frame_clk;
      x_q <= x_d;
      y_q <= y_d;
      vy_q <= vy_d;
      st_q <= st_d;
      status_q <= status_d;
    end
  end
  assign girl_x = x_q;
  assign girl_y = y_q;
  assign girl_status = status_q;
  assign in_air = st_q == AIR;
  assign px = {1'b0, DrawX};
  assign py = {1'b0, DrawY};
  assign gx = {1'b0, x_q};
  assign gy = {1'b0, y_q};
  assign is_girl = px >= gx && px < gx + 11'(SPRITE_W) && py >= gy && py < gy + 11'(SPRITE_H);
  assign girl_address = is_girl ? 10'((DrawY - y_q) * 10'(SPRITE_W) + (DrawX - x_q)) : '0;
endmodule

// File: tb/tb_girl_motion_ctrl.sv
// tb_girl_motion_ctrl: directed checks of reset, walking, wall clamps, jump arc, reset mid-jump and tick edge detection
module tb_girl_motion_ctrl;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_clk = 1'b0;
  logic [7:0] keycode0 = '0;
  logic [7:0] keycode1 = '0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic is_girl, in_air;
  logic [9:0] girl_address, girl_x, girl_y;
  logic [3:0] girl_status;
  int n_chk = 0;
  int n_fail = 0;
  girl_motion_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .keycode0(keycode0), .keycode1(keycode1), .DrawX(DrawX), .DrawY(DrawY),
    .is_girl(is_girl), .girl_address(girl_address), .girl_status(girl_status),
    .girl_x(girl_x), .girl_y(girl_y), .in_air(in_air)
  );
  always #10 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_tick;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    @(negedge Clk);
  endtask
  task automatic pix(input string tag, input int x, input int y, input logic eg, input int ea);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
    check({tag, "_is"}, 32'(is_girl), 32'(eg));
    check({tag, "_addr"}, 32'(girl_address), 32'(ea));
  endtask
  initial begin
    int ey, evy;
    repeat (2) @(negedge Clk);
    check("rst_x", 32'(girl_x), 40);
    check("rst_y", 32'(girl_y), 416);
    check("rst_status", 32'(girl_status), 0);
    check("rst_air", 32'(in_air), 0);
    Reset_n = 1'b1;
    pix("p_origin", 40, 416, 1'b1, 0);
    pix("p_last", 71, 447, 1'b1, 1023);
    pix("p_right", 72, 447, 1'b0, 0);
    pix("p_left", 39, 416, 1'b0, 0);
    pix("p_mid", 45, 419, 1'b1, 3 * 32 + 5);
    keycode0 = 8'h07;
    repeat (3) do_tick();
    check("right3_x", 32'(girl_x), 46);
    check("right3_status", 32'(girl_status), 1);
    repeat (280) do_tick();
    check("right_606", 32'(girl_x), 606);
    do_tick();
    check("right_clamp", 32'(girl_x), 608);
    do_tick();
    check("right_wall_x", 32'(girl_x), 608);
    check("right_wall_status", 32'(girl_status), 1);
    keycode0 = 8'h04;
    repeat (303) do_tick();
    check("left_2", 32'(girl_x), 2);
    check("left_status", 32'(girl_status), 2);
    do_tick();
    check("left_0", 32'(girl_x), 0);
    do_tick();
    check("left_wall_x", 32'(girl_x), 0);
    check("left_wall_status", 32'(girl_status), 2);
    keycode1 = 8'h07;
    do_tick();
    check("both_x", 32'(girl_x), 0);
    check("both_status", 32'(girl_status), 0);
    keycode1 = 8'h00;
    keycode0 = 8'h00;
    do_tick();
    check("none_status", 32'(girl_status), 0);
    pix("p_wall", 0, 420, 1'b1, 128);
    keycode0 = 8'h1A;
    @(negedge Clk);
    check("key_no_tick", 32'(in_air), 0);
    do_tick();
    check("jump_air", 32'(in_air), 1);
    check("jump_y", 32'(girl_y), 416);
    ey = 416;
    evy = -12;
    for (int k = 1; k <= 25; k++) begin
      ey = ey + evy;
      evy = evy + 1;
      do_tick();
      check($sformatf("arc_y%0d", k), 32'(girl_y), 32'(ey));
      check($sformatf("arc_air%0d", k), 32'(in_air), k == 25 ? 0 : 1);
    end
    do_tick();
    check("rejump_air", 32'(in_air), 1);
    check("rejump_y", 32'(girl_y), 416);
    do_tick();
    check("rejump_y1", 32'(girl_y), 404);
    do_tick();
    check("rejump_y2", 32'(girl_y), 393);
    @(negedge Clk);
    keycode0 = 8'h07;
    frame_clk = 1'b1;
    Reset_n = 1'b0;
    @(negedge Clk);
    check("midrst_y", 32'(girl_y), 416);
    check("midrst_air", 32'(in_air), 0);
    check("midrst_x", 32'(girl_x), 40);
    check("midrst_status", 32'(girl_status), 0);
    keycode0 = 8'h00;
    frame_clk = 1'b0;
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    do_tick();
    check("post_rst_y", 32'(girl_y), 416);
    check("post_rst_air", 32'(in_air), 0);
    keycode0 = 8'h07;
    frame_clk = 1'b1;
    repeat (20) @(negedge Clk);
    check("hold_x", 32'(girl_x), 42);
    check("hold_status", 32'(girl_status), 1);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    check("fall_x", 32'(girl_x), 42);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
